// File: rtl/l1d_evict_burst_arb_if.sv
// Handshake bundle between the MSHR evict queues / load pipe and the L1D data-array read port.
interface l1d_evict_burst_arb_if #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned WAY_W    = 2,
    parameter int unsigned TAG_W    = 20
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]          req_vld;
    logic [N_REQ-1:0]          req_rdy;
    logic [N_REQ*TAG_W-1:0]    req_tag;
    logic [N_REQ*INDEX_W-1:0]  req_index;
    logic [N_REQ*WAY_W-1:0]    req_way;
    logic [N_REQ*OFFSET_W-1:0] req_offset;

    logic                      ld_rd_vld;
    logic                      ld_rd_rdy;
    logic [INDEX_W-1:0]        ld_rd_index;
    logic [WAY_W-1:0]          ld_rd_way;
    logic [OFFSET_W-1:0]       ld_rd_offset;

    logic                      evict_buf_rdy;

    logic                      arr_rd_vld;
    logic                      arr_rd_rdy;
    logic [INDEX_W-1:0]        arr_rd_index;
    logic [WAY_W-1:0]          arr_rd_way;
    logic [OFFSET_W-1:0]       arr_rd_offset;
    logic                      arr_rd_src;
    logic [ID_W-1:0]           arr_rd_id;
    logic [TAG_W-1:0]          arr_rd_tag;
    logic                      arr_rd_last;
    logic                      busy;

    modport slave (
        input  req_vld, req_tag, req_index, req_way, req_offset,
        input  ld_rd_vld, ld_rd_index, ld_rd_way, ld_rd_offset,
        input  evict_buf_rdy, arr_rd_rdy,
        output req_rdy, ld_rd_rdy,
        output arr_rd_vld, arr_rd_index, arr_rd_way, arr_rd_offset,
        output arr_rd_src, arr_rd_id, arr_rd_tag, arr_rd_last, busy
    );

    modport master (
        output req_vld, req_tag, req_index, req_way, req_offset,
        output ld_rd_vld, ld_rd_index, ld_rd_way, ld_rd_offset,
        output evict_buf_rdy, arr_rd_rdy,
        input  req_rdy, ld_rd_rdy,
        input  arr_rd_vld, arr_rd_index, arr_rd_way, arr_rd_offset,
        input  arr_rd_src, arr_rd_id, arr_rd_tag, arr_rd_last, busy
    );
endinterface

// File: rtl/l1d_evict_burst_arb.sv
// Round-robin evict-burst expander sharing the L1D data-array read port with load-hit reads,
// with bounded load-over-evict starvation.
module l1d_evict_burst_arb #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned OFFSET_W      = 2,
    parameter int unsigned INDEX_W       = 6,
    parameter int unsigned WAY_W         = 2,
    parameter int unsigned TAG_W         = 20,
    parameter int unsigned LD_STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    l1d_evict_burst_arb_if.slave   bus
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned ST_W = $clog2(LD_STARVE_MAX + 1);

    typedef enum logic [0:0] {S_IDLE, S_BURST} state_t;

    state_t              r_state;
    logic [OFFSET_W-1:0] r_beat_cnt;
    logic [OFFSET_W-1:0] r_off;
    logic [ST_W-1:0]     r_starve_cnt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_gnt_id;
    logic [ID_W-1:0]     r_id;
    logic [N_REQ-1:0]    r_req_rdy;
    logic [TAG_W-1:0]    r_tag;
    logic [INDEX_W-1:0]  r_index;
    logic [WAY_W-1:0]    r_way;

    // Returns {found, id} of the first valid requester at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vld, input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int            p;
        res = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            p = int'(ptr) + i;
            if (p >= int'(N_REQ)) p -= int'(N_REQ);
            if (vld[p]) res = {1'b1, ID_W'(p)};
        end
        return res;
    endfunction

    logic [ID_W-1:0]  w_ptr_nx;
    logic [ID_W:0]    w_pick;
    logic [ID_W:0]    w_pick_nx;
    logic [N_REQ-1:0] w_pick_oh;
    logic [N_REQ-1:0] w_pick_nx_oh;
    logic             w_req_hs;
    logic             w_cand;
    logic             w_sel_ev;
    logic             w_ev_hs;
    logic             w_ld_hs;
    logic             w_last;

    assign w_ptr_nx     = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
    assign w_pick       = rr_pick(bus.req_vld, r_rr_ptr);
    assign w_pick_nx    = rr_pick(bus.req_vld, w_ptr_nx);
    assign w_pick_oh    = w_pick[ID_W]    ? (N_REQ'(1) << w_pick[ID_W-1:0])    : '0;
    assign w_pick_nx_oh = w_pick_nx[ID_W] ? (N_REQ'(1) << w_pick_nx[ID_W-1:0]) : '0;
    assign w_req_hs     = |(r_req_rdy & bus.req_vld);

    // Evict beat wins only when no load is asking or loads have used up their allowance.
    assign w_cand   = (r_state == S_BURST) & bus.evict_buf_rdy;
    assign w_sel_ev = w_cand & (~bus.ld_rd_vld | (r_starve_cnt >= ST_W'(LD_STARVE_MAX)));
    assign w_ev_hs  = w_sel_ev & bus.arr_rd_rdy;
    assign w_ld_hs  = bus.ld_rd_vld & ~w_sel_ev & bus.arr_rd_rdy;
    assign w_last   = &r_beat_cnt;

    assign bus.req_rdy       = r_req_rdy;
    assign bus.busy          = (r_state == S_BURST);
    assign bus.ld_rd_rdy     = w_ld_hs;
    assign bus.arr_rd_vld    = bus.ld_rd_vld | w_cand;
    assign bus.arr_rd_src    = w_sel_ev;
    assign bus.arr_rd_index  = w_sel_ev ? r_index : bus.ld_rd_index;
    assign bus.arr_rd_way    = w_sel_ev ? r_way : bus.ld_rd_way;
    assign bus.arr_rd_offset = w_sel_ev ? OFFSET_W'(r_off + r_beat_cnt) : bus.ld_rd_offset;
    assign bus.arr_rd_id     = r_id;
    assign bus.arr_rd_tag    = r_tag;
    assign bus.arr_rd_last   = w_sel_ev & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_beat_cnt   <= '0;
            r_off        <= '0;
            r_starve_cnt <= '0;
            r_rr_ptr     <= '0;
            r_gnt_id     <= '0;
            r_id         <= '0;
            r_req_rdy    <= '0;
            r_tag        <= '0;
            r_index      <= '0;
            r_way        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_starve_cnt <= '0;
                    if (w_req_hs) begin
                        r_tag      <= bus.req_tag[int'(r_gnt_id)*TAG_W +: TAG_W];
                        r_index    <= bus.req_index[int'(r_gnt_id)*INDEX_W +: INDEX_W];
                        r_way      <= bus.req_way[int'(r_gnt_id)*WAY_W +: WAY_W];
                        r_off      <= bus.req_offset[int'(r_gnt_id)*OFFSET_W +: OFFSET_W];
                        r_id       <= r_gnt_id;
                        r_beat_cnt <= '0;
                        r_req_rdy  <= '0;
                        r_state    <= S_BURST;
                    end else begin
                        r_req_rdy <= w_pick_oh;
                        r_gnt_id  <= w_pick[ID_W-1:0];
                    end
                end
                S_BURST: begin
                    r_req_rdy <= '0;
                    if (w_ev_hs) begin
                        r_starve_cnt <= '0;
                        r_beat_cnt   <= r_beat_cnt + OFFSET_W'(1);
                        // Pre-grant from the advanced pointer so a waiting request is taken next cycle.
                        if (w_last) begin
                            r_state   <= S_IDLE;
                            r_rr_ptr  <= w_ptr_nx;
                            r_req_rdy <= w_pick_nx_oh;
                            r_gnt_id  <= w_pick_nx[ID_W-1:0];
                        end
                    end else if (w_ld_hs && w_cand && (r_starve_cnt < ST_W'(LD_STARVE_MAX))) begin
                        r_starve_cnt <= r_starve_cnt + ST_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1d_evict_burst_arb.sv
// Scoreboard bench for l1d_evict_burst_arb: grants and evict beats are predicted at request time
// and compared as the array port hands them off.
module tb_l1d_evict_burst_arb;
    localparam int unsigned N_REQ         = 4;
    localparam int unsigned OFFSET_W      = 2;
    localparam int unsigned INDEX_W       = 6;
    localparam int unsigned WAY_W         = 2;
    localparam int unsigned TAG_W         = 20;
    localparam int unsigned LD_STARVE_MAX = 4;
    localparam int unsigned BEATS         = 1 << OFFSET_W;

    typedef struct {
        int                  id;
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  idx;
        logic [WAY_W-1:0]    way;
        logic [OFFSET_W-1:0] off;
        logic                last;
        int                  n;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    l1d_evict_burst_arb_if #(.N_REQ(N_REQ), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
                             .WAY_W(WAY_W), .TAG_W(TAG_W)) bus ();

    l1d_evict_burst_arb #(.N_REQ(N_REQ), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAY_W(WAY_W),
                          .TAG_W(TAG_W), .LD_STARVE_MAX(LD_STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t beat_q[$];
    int    gnt_q[$];
    bit    src_q[$];
    bit    chk_src = 1'b0;
    bit    ld_rand = 1'b0;
    logic [N_REQ-1:0] drop = '0;
    int    cyc = 0;
    int    ev_cnt = 0;
    int    gnt_cyc = 0;
    int    last_cyc = 0;
    int    gnt_gap = 0;
    int    first_gap = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (ld_rand) begin
            bus.ld_rd_index  = INDEX_W'($urandom);
            bus.ld_rd_way    = WAY_W'($urandom);
            bus.ld_rd_offset = OFFSET_W'($urandom);
        end
    endtask

    task automatic set_req_fields();
        for (int i = 0; i < int'(N_REQ); i++) begin
            bus.req_tag[i*TAG_W +: TAG_W]          = TAG_W'($urandom);
            bus.req_index[i*INDEX_W +: INDEX_W]    = INDEX_W'($urandom);
            bus.req_way[i*WAY_W +: WAY_W]          = WAY_W'($urandom);
            bus.req_offset[i*OFFSET_W +: OFFSET_W] = OFFSET_W'($urandom);
        end
    endtask

    task automatic raise_req(input int id);
        gnt_q.push_back(id);
        bus.req_vld[id] = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            tick();
            done = (bus.req_vld == '0) && !bus.busy && (beat_q.size() == 0) && (gnt_q.size() == 0);
        end
        if (!done) check("timeout_idle", 64'(0), 64'(1));
    endtask

    task automatic wait_ev(input int target, input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            tick();
            done = (ev_cnt >= target);
        end
        if (!done) check("timeout_beat", 64'(ev_cnt), 64'(target));
    endtask

    // Monitor: releases granted requests after their handshake edge and scores every port handoff.
    initial begin
        beat_t b;
        int    gid;
        int    e;
        logic [N_REQ-1:0] gnt;
        forever begin
            @(posedge clk);
            #1;
            if (drop != '0) begin
                bus.req_vld = bus.req_vld & ~drop;
                drop = '0;
            end
            @(negedge clk);
            if (rst_n) begin
                cyc++;
                gnt = bus.req_rdy & bus.req_vld;
                if (gnt != '0) begin
                    check("gnt_onehot", 64'($onehot(bus.req_rdy)), 64'(1));
                    gid = 0;
                    for (int i = 0; i < int'(N_REQ); i++) if (gnt[i]) gid = i;
                    if (gnt_q.size() == 0) begin
                        check("gnt_unexpected", 64'(gid), 64'(99));
                    end else begin
                        e = gnt_q.pop_front();
                        check("gnt_id", 64'(gid), 64'(e));
                    end
                    for (int n = 0; n < int'(BEATS); n++) begin
                        b.id   = gid;
                        b.tag  = bus.req_tag[gid*TAG_W +: TAG_W];
                        b.idx  = bus.req_index[gid*INDEX_W +: INDEX_W];
                        b.way  = bus.req_way[gid*WAY_W +: WAY_W];
                        b.off  = OFFSET_W'(int'(bus.req_offset[gid*OFFSET_W +: OFFSET_W]) + n);
                        b.last = (n == int'(BEATS) - 1);
                        b.n    = n;
                        beat_q.push_back(b);
                    end
                    gnt_gap = cyc - last_cyc;
                    gnt_cyc = cyc;
                    drop    = gnt;
                end
                if (bus.arr_rd_vld && bus.arr_rd_rdy) begin
                    if (chk_src && bus.busy) begin
                        if (src_q.size() == 0) check("src_extra", 64'(bus.arr_rd_src), 64'(2));
                        else check("src_order", 64'(bus.arr_rd_src), 64'(src_q.pop_front()));
                    end
                    if (bus.arr_rd_src) begin
                        ev_cnt++;
                        check("ld_rdy_on_evict", 64'(bus.ld_rd_rdy), 64'(0));
                        if (beat_q.size() == 0) begin
                            check("beat_unexpected", 64'(1), 64'(0));
                        end else begin
                            b = beat_q.pop_front();
                            check("beat_id", 64'(bus.arr_rd_id), 64'(b.id));
                            check("beat_tag", 64'(bus.arr_rd_tag), 64'(b.tag));
                            check("beat_index", 64'(bus.arr_rd_index), 64'(b.idx));
                            check("beat_way", 64'(bus.arr_rd_way), 64'(b.way));
                            check("beat_offset", 64'(bus.arr_rd_offset), 64'(b.off));
                            check("beat_last", 64'(bus.arr_rd_last), 64'(b.last));
                            if (b.n == 0) first_gap = cyc - gnt_cyc;
                            if (b.last) last_cyc = cyc;
                        end
                    end else begin
                        check("ld_rdy", 64'(bus.ld_rd_rdy), 64'(bus.ld_rd_vld));
                        check("ld_index", 64'(bus.arr_rd_index), 64'(bus.ld_rd_index));
                        check("ld_offset", 64'(bus.arr_rd_offset), 64'(bus.ld_rd_offset));
                        check("ld_way", 64'(bus.arr_rd_way), 64'(bus.ld_rd_way));
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst_n             = 1'b0;
        bus.req_vld       = '0;
        bus.ld_rd_vld     = 1'b1;
        bus.ld_rd_index   = 6'd17;
        bus.ld_rd_way     = 2'd2;
        bus.ld_rd_offset  = 2'd3;
        bus.arr_rd_rdy    = 1'b1;
        bus.evict_buf_rdy = 1'b1;
        set_req_fields();

        // Reset: outputs idle, load passes straight through; two requesters held from reset.
        gnt_q.push_back(0);
        gnt_q.push_back(3);
        bus.req_vld = 4'b1001;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_req_rdy", 64'(bus.req_rdy), 64'(0));
        check("rst_last", 64'(bus.arr_rd_last), 64'(0));
        check("rst_arr_vld", 64'(bus.arr_rd_vld), 64'(1));
        check("rst_ld_rdy", 64'(bus.ld_rd_rdy), 64'(1));
        check("rst_src", 64'(bus.arr_rd_src), 64'(0));
        check("rst_offset", 64'(bus.arr_rd_offset), 64'(3));
        bus.ld_rd_vld = 1'b0;
        tick();
        rst_n = 1'b1;

        // Requesters 0 and 3; 0 re-raised during its own burst must yield to 3.
        wait_ev(1, 50);
        raise_req(0);
        wait_idle(200);

        // Single requester 2, start offset 1: beats 1,2,3,0 directly after the grant.
        set_req_fields();
        bus.req_offset[2*OFFSET_W +: OFFSET_W] = 2'd1;
        raise_req(2);
        wait_idle(100);
        check("first_beat_latency", 64'(first_gap), 64'(1));
        check("burst_span", 64'(last_cyc - gnt_cyc), 64'(BEATS));

        // Continuous loads: 4 loads then 1 evict beat, repeated until the burst ends.
        set_req_fields();
        for (int k = 0; k < int'(BEATS); k++) begin
            for (int j = 0; j < int'(LD_STARVE_MAX); j++) src_q.push_back(1'b0);
            src_q.push_back(1'b1);
        end
        chk_src       = 1'b1;
        ld_rand       = 1'b1;
        bus.ld_rd_vld = 1'b1;
        raise_req(1);
        wait_idle(200);
        chk_src       = 1'b0;
        ld_rand       = 1'b0;
        bus.ld_rd_vld = 1'b0;
        check("src_pattern_left", 64'(src_q.size()), 64'(0));

        // Evict buffer stalls 3 cycles mid-burst; loads flow, no beat advances.
        set_req_fields();
        base = ev_cnt;
        raise_req(0);
        wait_ev(base + 2, 50);
        bus.evict_buf_rdy = 1'b0;
        bus.ld_rd_vld     = 1'b1;
        ld_rand           = 1'b1;
        base = ev_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_ld_rdy", 64'(bus.ld_rd_rdy), 64'(1));
            check("stall_src", 64'(bus.arr_rd_src), 64'(0));
            tick();
        end
        check("stall_no_beat", 64'(ev_cnt), 64'(base));
        bus.evict_buf_rdy = 1'b1;
        bus.ld_rd_vld     = 1'b0;
        ld_rand           = 1'b0;
        wait_idle(100);

        // Array port back-pressure: nothing accepted while arr_rd_rdy is low.
        set_req_fields();
        base = ev_cnt;
        raise_req(2);
        wait_ev(base + 1, 50);
        bus.arr_rd_rdy = 1'b0;
        bus.ld_rd_vld  = 1'b1;
        base = ev_cnt;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_ld_rdy", 64'(bus.ld_rd_rdy), 64'(0));
            check("bp_arr_vld", 64'(bus.arr_rd_vld), 64'(1));
            tick();
        end
        check("bp_no_beat", 64'(ev_cnt), 64'(base));
        bus.arr_rd_rdy = 1'b1;
        bus.ld_rd_vld  = 1'b0;
        wait_idle(100);

        // Reset two beats into a burst: aborted, pointer back to 0 so 1 beats 3.
        base = ev_cnt;
        raise_req(1);
        wait_ev(base + 2, 50);
        rst_n = 1'b0;
        beat_q.delete();
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_req_rdy", 64'(bus.req_rdy), 64'(0));
        check("abort_arr_vld", 64'(bus.arr_rd_vld), 64'(0));
        tick();
        rst_n = 1'b1;
        raise_req(1);
        raise_req(3);
        wait_idle(200);

        // Request pending at the last beat is granted the next cycle.
        set_req_fields();
        base = ev_cnt;
        raise_req(0);
        wait_ev(base + 1, 50);
        raise_req(1);
        wait_idle(200);
        check("regrant_gap", 64'(gnt_gap), 64'(1));
        check("regrant_first_beat", 64'(first_gap), 64'(1));

        check("beats_left", 64'(beat_q.size()), 64'(0));
        check("grants_left", 64'(gnt_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
